compensator: RTL and testbench

//   Sparse 3-tap FIR that compensates CIC decimator droop.

---
 rtl/compensator.sv | 76 +++++++
 tb/tb_compensator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/compensator.sv
// Sparse 3-tap CIC droop compensator: y[n] = x[n] - 10*x[n-D] + x[n-2D].
// The delay line advances only on accepted samples; the result is registered with a valid/ready flag.
module compensator #(
  parameter int InputLengthBits  = 12,
  parameter int OutputLengthBits = 19,
  parameter int FilterOrder      = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [InputLengthBits-1:0]  in,
  input  logic                        in_valid,
  output logic [OutputLengthBits:0]   out,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int OutW = OutputLengthBits + 1;
  localparam int Taps = 2 * FilterOrder;

  function automatic logic [OutW-1:0] sext(input logic [InputLengthBits-1:0] v);
    sext = {{(OutW - InputLengthBits){v[InputLengthBits-1]}}, v};
  endfunction

  logic [InputLengthBits-1:0] dly_q [Taps];
  logic [InputLengthBits-1:0] dly_d [Taps];
  logic [OutW-1:0]            out_q;
  logic [OutW-1:0]            out_d;
  logic [OutW-1:0]            acc_s;
  logic [OutW-1:0]            mid_s;
  logic                       out_valid_q;
  logic                       out_valid_d;

  // Filter arithmetic; the x10 tap is built from two shifts and wraps modulo 2^OutW.
  always_comb begin
    mid_s = sext(dly_q[FilterOrder-1]);
    acc_s = sext(in) - ((mid_s << 3'd3) + (mid_s << 3'd1)) + sext(dly_q[Taps-1]);
  end

  // Next-state: a new sample wins over a consume in the same cycle.
  always_comb begin
    dly_d       = dly_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (in_valid) begin
      dly_d[0] = in;
      for (int i = 1; i < Taps; i++) begin
        dly_d[i] = dly_q[i-1];
      end
      out_d       = acc_s;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset clears history so filtering restarts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Taps; i++) begin
        dly_q[i] <= '0;
      end
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_compensator.sv
// Directed bench for compensator (12-bit in, 20-bit out, D=3) with hand-computed expectations.
module tb_compensator;

  logic        clk;
  logic        rst;
  logic [11:0] in;
  logic        in_valid;
  logic [19:0] out;
  logic        out_valid;
  logic        out_ready;

  int checks_r;
  int failures_r;

  compensator #(
    .InputLengthBits (12),
    .OutputLengthBits(19),
    .FilterOrder     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [31:0] sout();
    return {{12{out[19]}}, out};
  endfunction

  int imp_exp [10];
  int stp_exp [9];
  int neg_exp [9];

  initial begin
    checks_r   = 0;
    failures_r = 0;
    imp_exp = '{2047, 0, 0, -20470, 0, 0, 2047, 0, 0, 0};
    stp_exp = '{2047, 2047, 2047, -18423, -18423, -18423, -16376, -16376, -16376};
    neg_exp = '{-2048, -2048, -2048, 18432, 18432, 18432, 16384, 16384, 16384};

    rst       = 1'b0;
    in        = 12'hAAA;
    in_valid  = 1'b1;
    out_ready = 1'b0;

    // Reset held with active inputs.
    for (int i = 0; i < 1000; i++) begin
      out_ready = i[0];
      tick();
      check_eq("rst_out", sout(), 32'sd0);
      check_eq("rst_valid", {31'd0, out_valid}, 32'sd0);
    end

    // Idle after release: nothing accepted.
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      check_eq("idle_out", sout(), 32'sd0);
      check_eq("idle_valid", {31'd0, out_valid}, 32'sd0);
    end

    // Zero samples streaming.
    in       = 12'h000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("zero_out", sout(), 32'sd0);
      check_eq("zero_valid", {31'd0, out_valid}, 32'sd1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("drain_valid", {31'd0, out_valid}, 32'sd0);

    // Single result held without ready, then consumed.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("hold_valid0", {31'd0, out_valid}, 32'sd1);
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq("hold_valid", {31'd0, out_valid}, 32'sd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("consume_valid", {31'd0, out_valid}, 32'sd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("after_consume_valid", {31'd0, out_valid}, 32'sd0);
    end

    // Impulse response.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in        = 12'd2047;
    for (int i = 0; i < 10; i++) begin
      tick();
      in = 12'd0;
      check_eq("impulse", sout(), imp_exp[i]);
      check_eq("impulse_valid", {31'd0, out_valid}, 32'sd1);
    end

    // Positive full-scale step.
    in = 12'd2047;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq("step_pos", sout(), stp_exp[i]);
    end

    // Mid-run reset clears outputs and history.
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_out", sout(), 32'sd0);
    check_eq("midrst_valid", {31'd0, out_valid}, 32'sd0);
    tick();
    check_eq("midrst_hold", sout(), 32'sd0);
    rst = 1'b1;

    // Negative full-scale step from empty history.
    in = 12'h800;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq("step_neg", sout(), neg_exp[i]);
    end

    // Overrun: new result overwrites unconsumed one, then holds.
    out_ready = 1'b0;
    in        = 12'd5;
    tick();
    check_eq("overrun_out", sout(), 32'sd18437);
    check_eq("overrun_valid", {31'd0, out_valid}, 32'sd1);
    in_valid = 1'b0;
    tick();
    check_eq("overrun_hold", sout(), 32'sd18437);
    check_eq("overrun_hold_valid", {31'd0, out_valid}, 32'sd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
